// File: rtl/regfile_valid_tracker_pkg.sv
// rtl/regfile_valid_tracker_pkg.sv - shared sizes, types and recovery states for the register validity tracker
package regfile_valid_tracker_pkg;

    localparam int AREGS    = 128;
    localparam int RENTRIES = 16;
    localparam int RBIT     = 4;
    localparam int QSLOTS   = 2;
    localparam int CSLOTS   = 2;
    localparam int RPORTS   = 4;
    localparam int TAGW     = 7;

    typedef logic [RBIT-1:0] rid_t;
    typedef logic [TAGW-1:0] reg_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RESTORE = 2'd2
    } rec_state_t;

    // Cycles spent in FLUSH so that RESTORE coincides with the source-table restore.
    localparam logic [1:0] FLUSH_CYCLES = 2'd2;

endpackage

// File: rtl/regfile_valid_lookup.sv
// rtl/regfile_valid_lookup.sv - one registered operand-ready lookup port with commit bypass
module regfile_valid_lookup
    import regfile_valid_tracker_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  reg_tag_t                i_rs,
    input  logic [AREGS-1:0]        i_rf_v,
    input  rid_t [AREGS-1:0]        i_rf_source,
    input  logic [CSLOTS-1:0]       i_commit_hit,
    input  reg_tag_t [CSLOTS-1:0]   i_commit_tgt,
    output logic                    o_rs_v,
    output rid_t                    o_rs_src
);

    logic w_bypass;
    logic w_v_next;
    logic r_rs_v;
    rid_t r_rs_src;

    // A commit landing this cycle makes the operand ready even though rf_v updates only next cycle.
    always_comb begin
        w_bypass = 1'b0;
        for (int k = 0; k < CSLOTS; k++) begin
            if (i_commit_hit[k] && (i_commit_tgt[k] == i_rs)) begin
                w_bypass = 1'b1;
            end
        end
        w_v_next = (i_rs == '0) | i_rf_v[i_rs] | w_bypass;
    end

    // Register the lookup result for the queue stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs_v   <= 1'b1;
            r_rs_src <= '0;
        end else begin
            r_rs_v   <= w_v_next;
            r_rs_src <= i_rf_source[i_rs];
        end
    end

    assign o_rs_v   = r_rs_v;
    assign o_rs_src = r_rs_src;

endmodule

// File: rtl/regfile_valid_tracker.sv
// rtl/regfile_valid_tracker.sv - per-register committed/pending validity with branch-miss rebuild
module regfile_valid_tracker
    import regfile_valid_tracker_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    branchmiss,
    input  logic [QSLOTS-1:0]       queuedOn,
    input  logic [QSLOTS-1:0]       slot_rfw,
    input  reg_tag_t [QSLOTS-1:0]   Rd,
    input  logic [QSLOTS-1:0]       brk,
    input  logic [QSLOTS-1:0]       slot_jmp,
    input  logic [QSLOTS-1:0]       take_branch,
    input  logic [CSLOTS-1:0]       commit_v,
    input  logic [CSLOTS-1:0]       commit_rfw,
    input  reg_tag_t [CSLOTS-1:0]   commit_tgt,
    input  rid_t [CSLOTS-1:0]       commit_rid,
    input  rid_t [AREGS-1:0]        rf_source,
    input  logic [RENTRIES-1:0]     rob_latest,
    input  logic [RENTRIES-1:0]     rob_done,
    input  reg_tag_t [RENTRIES-1:0] rob_tgt,
    input  reg_tag_t [RPORTS-1:0]   rs,
    output logic [RPORTS-1:0]       rs_v,
    output rid_t [RPORTS-1:0]       rs_src,
    output logic [AREGS-1:0]        rf_v,
    output logic                    recovering
);

    rec_state_t         r_state;
    rec_state_t         w_state_next;
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_next;
    logic [1:0]         w_cnt_dec;
    logic               r_bm_d;
    logic               w_bm_edge;
    logic [AREGS-1:0]   r_rf_v;
    logic [AREGS-1:0]   w_rf_v_next;
    logic               w_q_en;
    logic               w_q_clr0;
    logic               w_q_clr1;
    logic [CSLOTS-1:0]  w_commit_hit;
    logic               w_unused;

    // Slot-1 qualifiers are only meaningful for slot 0.
    assign w_unused = &{1'b0, brk[1], slot_jmp[1], take_branch[1]};

    assign w_bm_edge = branchmiss & ~r_bm_d;
    assign w_cnt_dec = r_cnt - 2'd1;

    // Slot 1 is suppressed when a queued slot 0 diverts control flow.
    assign w_q_en   = (r_state == ST_IDLE) & ce;
    assign w_q_clr0 = w_q_en & queuedOn[0] & slot_rfw[0];
    assign w_q_clr1 = w_q_en & queuedOn[1] & slot_rfw[1] &
                      (~queuedOn[0] | (~brk[0] & ~(slot_jmp[0] | take_branch[0])));

    // A commit only revalidates a register if it is still that register's recorded producer.
    always_comb begin
        w_commit_hit = '0;
        for (int k = 0; k < CSLOTS; k++) begin
            w_commit_hit[k] = (r_state != ST_RESTORE) & commit_v[k] & commit_rfw[k] &
                              (rf_source[commit_tgt[k]] == commit_rid[k]);
        end
    end

    // Recovery sequencing: FLUSH counts down so RESTORE aligns with the source-table restore.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_bm_edge) begin
                    w_state_next = ST_FLUSH;
                    w_cnt_next   = FLUSH_CYCLES;
                end
            end
            ST_FLUSH: begin
                if (w_bm_edge) begin
                    w_cnt_next = FLUSH_CYCLES;
                end else begin
                    w_cnt_next = w_cnt_dec;
                    if (w_cnt_dec == 2'd0) begin
                        w_state_next = ST_RESTORE;
                    end
                end
            end
            ST_RESTORE: begin
                if (w_bm_edge) begin
                    w_state_next = ST_FLUSH;
                    w_cnt_next   = FLUSH_CYCLES;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 2'd0;
            end
        endcase
    end

    // Next validity: rebuild from in-flight ROB producers on RESTORE, else commit sets then queue clears.
    always_comb begin
        w_rf_v_next = r_rf_v;
        if (r_state == ST_RESTORE) begin
            w_rf_v_next = '1;
            for (int n = 0; n < RENTRIES; n++) begin
                if (rob_latest[n] && !rob_done[n]) begin
                    w_rf_v_next[rob_tgt[n]] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < CSLOTS; k++) begin
                if (w_commit_hit[k]) begin
                    w_rf_v_next[commit_tgt[k]] = 1'b1;
                end
            end
            if (w_q_clr0) begin
                w_rf_v_next[Rd[0]] = 1'b0;
            end
            if (w_q_clr1) begin
                w_rf_v_next[Rd[1]] = 1'b0;
            end
        end
        w_rf_v_next[0] = 1'b1;
    end

    // State, flush counter, branch-miss history and validity bitmap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_bm_d  <= 1'b0;
            r_rf_v  <= '1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bm_d  <= branchmiss;
            r_rf_v  <= w_rf_v_next;
        end
    end

    for (genvar p = 0; p < RPORTS; p++) begin : g_lookup
        regfile_valid_lookup u_lookup (
            .clk          (clk),
            .rst          (rst),
            .i_rs         (rs[p]),
            .i_rf_v       (r_rf_v),
            .i_rf_source  (rf_source),
            .i_commit_hit (w_commit_hit),
            .i_commit_tgt (commit_tgt),
            .o_rs_v       (rs_v[p]),
            .o_rs_src     (rs_src[p])
        );
    end

    assign rf_v       = r_rf_v;
    assign recovering = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regfile_valid_tracker.sv
// tb/tb_regfile_valid_tracker.sv - scoreboard bench for regfile_valid_tracker
module tb_regfile_valid_tracker;
    import regfile_valid_tracker_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             branchmiss;
    logic [1:0]       queuedOn, slot_rfw, brk, slot_jmp, take_branch;
    reg_tag_t [1:0]   Rd;
    logic [1:0]       commit_v, commit_rfw;
    reg_tag_t [1:0]   commit_tgt;
    rid_t [1:0]       commit_rid;
    rid_t [127:0]     rf_source;
    logic [15:0]      rob_latest, rob_done;
    reg_tag_t [15:0]  rob_tgt;
    reg_tag_t [3:0]   rs;
    logic [3:0]       rs_v;
    rid_t [3:0]       rs_src;
    logic [127:0]     rf_v;
    logic             recovering;

    typedef struct {
        string        tag;
        int           sel;
        int           idx;
        logic [127:0] exp;
    } sb_t;

    sb_t          sb[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] exp_rf;

    regfile_valid_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .branchmiss  (branchmiss),
        .queuedOn    (queuedOn),
        .slot_rfw    (slot_rfw),
        .Rd          (Rd),
        .brk         (brk),
        .slot_jmp    (slot_jmp),
        .take_branch (take_branch),
        .commit_v    (commit_v),
        .commit_rfw  (commit_rfw),
        .commit_tgt  (commit_tgt),
        .commit_rid  (commit_rid),
        .rf_source   (rf_source),
        .rob_latest  (rob_latest),
        .rob_done    (rob_done),
        .rob_tgt     (rob_tgt),
        .rs          (rs),
        .rs_v        (rs_v),
        .rs_src      (rs_src),
        .rf_v        (rf_v),
        .recovering  (recovering)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] observe(input int sel, input int idx);
        case (sel)
            0:       return rf_v;
            1:       return 128'(rs_v[idx]);
            2:       return 128'(rs_src[idx]);
            default: return 128'(recovering);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int idx, input logic [127:0] v);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.idx = idx;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk_val(e.tag, observe(e.sel, e.idx), e.exp);
        end
    endtask

    task automatic clear_in();
        ce          = 1'b1;
        branchmiss  = 1'b0;
        queuedOn    = '0;
        slot_rfw    = '0;
        Rd          = '0;
        brk         = '0;
        slot_jmp    = '0;
        take_branch = '0;
        commit_v    = '0;
        commit_rfw  = '0;
        commit_tgt  = '0;
        commit_rid  = '0;
        rs          = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        rob_latest = '0;
        rob_done   = '0;
        rob_tgt    = '0;
        for (int r = 0; r < 128; r++) rf_source[r] = rid_t'(r * 7);
        rf_source[0] = 4'd9;
        rf_source[5] = 4'd3;
        rf_source[7] = 4'd6;

        #12;
        chk_val("reset_rf_v", rf_v, {128{1'b1}});
        chk_val("reset_rs_v", 128'(rs_v), 128'hF);
        chk_val("reset_rs_src", 128'(rs_src), 128'h0);
        chk_val("reset_recovering", 128'(recovering), 128'h0);
        rst = 1'b0;
        exp_rf = {128{1'b1}};

        // both slots queued, no flow change
        queuedOn = 2'b11; slot_rfw = 2'b11; Rd[0] = 7'd5; Rd[1] = 7'd9;
        exp_rf[5] = 1'b0; exp_rf[9] = 1'b0;
        push("q_both", 0, 0, exp_rf);
        tick();

        // taken branch in slot 0 suppresses slot 1
        clear_in();
        queuedOn = 2'b11; slot_rfw = 2'b11; Rd[0] = 7'd10; Rd[1] = 7'd11; take_branch[0] = 1'b1;
        exp_rf[10] = 1'b0;
        push("q_take_branch", 0, 0, exp_rf);
        tick();

        // matching commit sets, stale commit in slot 1 ignored
        clear_in();
        commit_v = 2'b11; commit_rfw = 2'b11;
        commit_tgt[0] = 7'd5; commit_rid[0] = 4'd3;
        commit_tgt[1] = 7'd9; commit_rid[1] = 4'd2;
        exp_rf[5] = 1'b1;
        push("commit_match", 0, 0, exp_rf);
        tick();

        clear_in();
        queuedOn = 2'b01; slot_rfw = 2'b01; Rd[0] = 7'd5;
        exp_rf[5] = 1'b0;
        push("q_reclear5", 0, 0, exp_rf);
        tick();

        clear_in();
        commit_v = 2'b01; commit_rfw = 2'b01; commit_tgt[0] = 7'd5; commit_rid[0] = 4'd2;
        push("commit_stale", 0, 0, exp_rf);
        tick();

        clear_in();
        queuedOn = 2'b01; slot_rfw = 2'b01; Rd[0] = 7'd7;
        exp_rf[7] = 1'b0;
        push("q_clear7", 0, 0, exp_rf);
        tick();

        // queue clear beats same-cycle commit
        clear_in();
        queuedOn = 2'b01; slot_rfw = 2'b01; Rd[0] = 7'd7;
        commit_v = 2'b01; commit_rfw = 2'b01; commit_tgt[0] = 7'd7; commit_rid[0] = 4'd6;
        push("clear_wins", 0, 0, exp_rf);
        tick();

        // two commit slots on reg 7, lookups with bypass
        clear_in();
        commit_v = 2'b11; commit_rfw = 2'b11;
        commit_tgt[0] = 7'd7; commit_rid[0] = 4'd6;
        commit_tgt[1] = 7'd7; commit_rid[1] = 4'd6;
        rs[0] = 7'd7; rs[1] = 7'd9; rs[2] = 7'd0; rs[3] = 7'd5;
        exp_rf[7] = 1'b1;
        push("dual_commit", 0, 0, exp_rf);
        push("rs0_bypass_v", 1, 0, 128'h1);
        push("rs0_src", 2, 0, 128'h6);
        push("rs1_pending_v", 1, 1, 128'h0);
        push("rs1_src", 2, 1, 128'(rf_source[9]));
        push("rs2_zero_v", 1, 2, 128'h1);
        push("rs2_zero_src", 2, 2, 128'h9);
        push("rs3_v", 1, 3, 128'h0);
        push("rs3_src", 2, 3, 128'h3);
        tick();

        // writes to register 0 never clear it
        clear_in();
        queuedOn = 2'b11; slot_rfw = 2'b11; Rd[0] = 7'd0; Rd[1] = 7'd0;
        push("q_reg0", 0, 0, exp_rf);
        tick();

        // ce low blocks queue clears
        clear_in();
        ce = 1'b0; queuedOn = 2'b11; slot_rfw = 2'b11; Rd[0] = 7'd20; Rd[1] = 7'd21;
        push("ce_low", 0, 0, exp_rf);
        tick();

        // slot 1 alone is not qualified by slot-0 brk
        clear_in();
        queuedOn = 2'b10; slot_rfw = 2'b10; Rd[1] = 7'd22; brk[0] = 1'b1;
        exp_rf[22] = 1'b0;
        push("q_slot1_only", 0, 0, exp_rf);
        tick();

        // clear everything
        for (int r = 1; r < 128; r += 2) begin
            clear_in();
            queuedOn = 2'b11; slot_rfw = 2'b11;
            Rd[0] = reg_tag_t'(r); Rd[1] = reg_tag_t'(r + 1);
            tick();
        end
        clear_in();
        exp_rf = 128'h1;
        push("all_cleared", 0, 0, exp_rf);
        tick();

        // branch-miss recovery
        rob_latest[4] = 1'b1; rob_done[4] = 1'b0; rob_tgt[4] = 7'd12;
        rob_latest[6] = 1'b1; rob_done[6] = 1'b1; rob_tgt[6] = 7'd30;
        rob_tgt[8] = 7'd40;
        branchmiss = 1'b1;
        push("bm_rec_t1", 3, 0, 128'h1);
        push("bm_rf_t1", 0, 0, exp_rf);
        tick();

        clear_in();
        commit_v = 2'b01; commit_rfw = 2'b01; commit_tgt[0] = 7'd60; commit_rid[0] = rf_source[60];
        exp_rf[60] = 1'b1;
        push("bm_rec_t2", 3, 0, 128'h1);
        push("flush_commit", 0, 0, exp_rf);
        tick();

        clear_in();
        queuedOn = 2'b01; slot_rfw = 2'b01; Rd[0] = 7'd60;
        push("bm_rec_t3", 3, 0, 128'h1);
        push("flush_q_ignored", 0, 0, exp_rf);
        tick();

        clear_in();
        commit_v = 2'b01; commit_rfw = 2'b01; commit_tgt[0] = 7'd12; commit_rid[0] = rf_source[12];
        exp_rf = {128{1'b1}};
        exp_rf[12] = 1'b0;
        push("bm_rec_done", 3, 0, 128'h0);
        push("restore_rf", 0, 0, exp_rf);
        tick();

        // second edge during FLUSH restarts the countdown
        clear_in();
        rob_latest = '0;
        branchmiss = 1'b1;
        push("rs_rec0", 3, 0, 128'h1);
        tick();
        branchmiss = 1'b0;
        push("rs_rec1", 3, 0, 128'h1);
        tick();
        branchmiss = 1'b1;
        push("rs_rec2", 3, 0, 128'h1);
        tick();
        branchmiss = 1'b0;
        push("rs_rec3", 3, 0, 128'h1);
        tick();
        push("rs_rec4", 3, 0, 128'h1);
        tick();
        exp_rf = {128{1'b1}};
        push("rs_rec5", 3, 0, 128'h0);
        push("rs_restore_rf", 0, 0, exp_rf);
        tick();

        // async reset while in FLUSH
        clear_in();
        queuedOn = 2'b01; slot_rfw = 2'b01; Rd[0] = 7'd33;
        exp_rf[33] = 1'b0;
        push("pre_reset_clear", 0, 0, exp_rf);
        tick();
        clear_in();
        branchmiss = 1'b1;
        push("pre_reset_flush", 3, 0, 128'h1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_val("async_rst_rf_v", rf_v, {128{1'b1}});
        chk_val("async_rst_recovering", 128'(recovering), 128'h0);
        chk_val("async_rst_rs_v", 128'(rs_v), 128'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
